i281_datamem_n: RTL and testbench
=================================

I281_DATAMEM_N -- requirements
Module: i281_datamem_n

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning number of words; legal range 2..2**ADDR_W.
REQ-004 The block SHALL have port clock, input, 1 bit, meaning the single clock, all state on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-006 The block SHALL have port run, input, 1 bit, meaning 1 = CPU execute mode, 0 = load mode.
REQ-007 The block SHALL have port write_en, input, 1 bit, meaning CPU store strobe.
REQ-008 The block SHALL have ports write_addr (input, ADDR_W) and write_data (input, DATA_W), meaning CPU store address and data.
REQ-009 The block SHALL have ports read_addr_a and read_addr_b (input, ADDR_W each), meaning two independent read addresses.
REQ-010 The block SHALL have ports read_data_a and read_data_b (output, DATA_W each), meaning read data.
REQ-011 The block SHALL have ports load_strobe (input, 1) and load_data (input, DATA_W), meaning debounced load key and switch value.
REQ-012 The block SHALL have port load_ptr_clr, input, 1 bit, meaning clear the load pointer.
REQ-013 The block SHALL have port load_ptr, output, ADDR_W, meaning current load pointer.
REQ-014 The block SHALL have port mem_flat, output, DEPTH*DATA_W, meaning all words for display, word k at bits [k*DATA_W +: DATA_W].

Function
REQ-015 Reads SHALL be combinational: read_data_x = mem[read_addr_x], zero latency, two ports fully independent.
REQ-016 A read with address >= DEPTH SHALL return all zeros.
REQ-017 A CPU write SHALL occur on a rising clock edge when run=1 and write_en=1 and write_addr < DEPTH; it is visible on reads and on mem_flat after that edge.
REQ-018 A read of the address being written in the same cycle SHALL return the old value until the edge (no bypass).
REQ-019 write_en SHALL be ignored when run=0; writes with write_addr >= DEPTH SHALL be dropped silently.
REQ-020 The block SHALL register load_strobe each cycle into strobe_q; a load event is load_strobe=1 and strobe_q=0.
REQ-021 A load event with run=0 and load_ptr_clr=0 SHALL write load_data to mem[load_ptr] and increment load_ptr on the same edge.
REQ-022 load_ptr SHALL wrap from DEPTH-1 to 0.
REQ-023 A level held high SHALL produce exactly one load event; the next requires a 0 sample first.
REQ-024 With run=1, load events SHALL be ignored and load_ptr held.
REQ-025 load_ptr_clr=1 SHALL set load_ptr to 0 on the edge, take priority over a coincident load event, and suppress that event's write.
REQ-026 A run 0->1 or 1->0 transition SHALL NOT alter memory or load_ptr.

Reset
REQ-027 Reset SHALL asynchronously clear all DEPTH words to 0, load_ptr to 0, and strobe_q to 1, so a key held through reset release produces no load event.
REQ-028 Reset asserted mid-operation SHALL discard any same-cycle write; outputs SHALL read 0 while reset is high.

Structure
REQ-029 Default widths (DATA_W=8, ADDR_W=4, DEPTH=16) SHALL live as constants in the shared i281 package, alongside the other CPU width constants.
REQ-030 Edge detection SHALL be a sub-module i281_rise_detect (clock, reset, in, rise; reset preloads 1), reusable for other front-panel keys.
REQ-031 Storage SHALL be a register array (no RAM macro), enabling mem_flat and async reset.

Verification
REQ-032 Reset, run=0, load_data=8'h11/22/33 with three strobe pulses -> mem[0..2]=11,22,33, load_ptr=3.
REQ-033 load_ptr=15, load_data=8'hAA, one pulse -> mem[15]=AA, load_ptr=0; strobe held 10 cycles -> one write only.
REQ-034 run=1, write_en=1, addr=5, data=8'h7E, read_addr_a=5 -> read_data_a old value before edge, 7E after; read_addr_b=5 simultaneously returns the same values.
REQ-035 run=0, write_en=1, addr=3 -> mem[3] unchanged; run=1 with load pulse -> memory and load_ptr unchanged.
REQ-036 load_ptr=6, load_ptr_clr and load event in the same cycle -> load_ptr=0, mem[6] unchanged.
REQ-037 DEPTH=10, ADDR_W=4: write to addr 12 -> dropped, read addr 12 -> 0; load at ptr 9 -> wraps to 0; reset with strobe high -> all zeros, no load on release.

Source files
------------

// File: rtl/i281_pkg.sv
// Shared i281 CPU constants: datapath, address and memory sizing used across the core.
package i281_pkg;
   localparam int I281_DATA_W   = 8;
   localparam int I281_ADDR_W   = 4;
   localparam int I281_DEPTH    = 16;
   localparam int I281_PC_W     = 6;
   localparam int I281_INSTR_W  = 16;
   localparam int I281_NUM_REGS = 4;
endpackage

// File: rtl/i281_rise_detect.sv
// Rising-edge detector for front-panel keys; reset preloads the history to 1 so a
// key already held when reset releases does not register as a press.
module i281_rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic rise
);

   logic strobe_q;
   logic strobe_d;

   always_comb begin
      strobe_d = in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         strobe_q <= 1'b1;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   assign rise = in & ~strobe_q;

endmodule

// File: rtl/i281_datamem_n.sv
// i281 data memory: register array with two combinational read ports, a CPU store
// port in run mode, and a keyed front-panel loader with an auto-incrementing pointer.
module i281_datamem_n
   import i281_pkg::*;
#(
   parameter int DATA_W = I281_DATA_W,
   parameter int ADDR_W = I281_ADDR_W,
   parameter int DEPTH  = I281_DEPTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    write_en,
   input  logic [ADDR_W-1:0]       write_addr,
   input  logic [DATA_W-1:0]       write_data,
   input  logic [ADDR_W-1:0]       read_addr_a,
   input  logic [ADDR_W-1:0]       read_addr_b,
   output logic [DATA_W-1:0]       read_data_a,
   output logic [DATA_W-1:0]       read_data_b,
   input  logic                    load_strobe,
   input  logic [DATA_W-1:0]       load_data,
   input  logic                    load_ptr_clr,
   output logic [ADDR_W-1:0]       load_ptr,
   output logic [DEPTH*DATA_W-1:0] mem_flat
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [ADDR_W-1:0] load_ptr_q;
   logic [ADDR_W-1:0] load_ptr_d;
   logic              load_event;

   i281_rise_detect u_load_rise (
      .clock (clock),
      .reset (reset),
      .in    (load_strobe),
      .rise  (load_event)
   );

   // Address decode by compare loop: out-of-range addresses match no word, so
   // stores to them vanish and reads of them return zero.
   always_comb begin
      mem_d      = mem_q;
      load_ptr_d = load_ptr_q;
      if (run && write_en) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (write_addr == ADDR_W'(k)) mem_d[k] = write_data;
         end
      end
      if (load_ptr_clr) begin
         load_ptr_d = '0;
      end else if (!run && load_event) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (load_ptr_q == ADDR_W'(k)) mem_d[k] = load_data;
         end
         load_ptr_d = (load_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : load_ptr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
         load_ptr_q <= '0;
      end else begin
         mem_q      <= mem_d;
         load_ptr_q <= load_ptr_d;
      end
   end

   always_comb begin
      read_data_a = '0;
      read_data_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (read_addr_a == ADDR_W'(k)) read_data_a = mem_q[k];
         if (read_addr_b == ADDR_W'(k)) read_data_b = mem_q[k];
      end
   end

   assign load_ptr = load_ptr_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
   end

endmodule

// File: tb/tb_i281_datamem_n.sv
// Directed bench for i281_datamem_n: default 16-word instance plus a 10-word instance.
module tb_i281_datamem_n;

   logic         clk = 1'b0;
   logic         rst;
   logic         run;
   logic         write_en;
   logic [3:0]   write_addr;
   logic [7:0]   write_data;
   logic [3:0]   ra_a;
   logic [3:0]   ra_b;
   logic         load_strobe;
   logic [7:0]   load_data;
   logic         load_ptr_clr;
   logic [7:0]   rd_a, rd_b, rd2_a, rd2_b;
   logic [3:0]   lp, lp2;
   logic [127:0] flat;
   logic [79:0]  flat2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   i281_datamem_n dut (
      .clock(clk), .reset(rst), .run(run), .write_en(write_en),
      .write_addr(write_addr), .write_data(write_data),
      .read_addr_a(ra_a), .read_addr_b(ra_b),
      .read_data_a(rd_a), .read_data_b(rd_b),
      .load_strobe(load_strobe), .load_data(load_data),
      .load_ptr_clr(load_ptr_clr), .load_ptr(lp), .mem_flat(flat)
   );

   i281_datamem_n #(.DATA_W(8), .ADDR_W(4), .DEPTH(10)) dut10 (
      .clock(clk), .reset(rst), .run(run), .write_en(write_en),
      .write_addr(write_addr), .write_data(write_data),
      .read_addr_a(ra_a), .read_addr_b(ra_b),
      .read_data_a(rd2_a), .read_data_b(rd2_b),
      .load_strobe(load_strobe), .load_data(load_data),
      .load_ptr_clr(load_ptr_clr), .load_ptr(lp2), .mem_flat(flat2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] d);
      load_data   = d;
      load_strobe = 1'b1;
      step();
      load_strobe = 1'b0;
      step();
   endtask

   task automatic test_reset();
      run = 0; write_en = 0; write_addr = 0; write_data = 0;
      ra_a = 0; ra_b = 0; load_strobe = 0; load_data = 0; load_ptr_clr = 0;
      rst = 1'b1;
      #2;
      total++; if (flat !== '0) begin bad++; $display("FAIL reset_mem got=%h exp=0", flat); end
      total++; if (lp !== 4'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", lp); end
      total++; if (rd_a !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", rd_a); end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_load_seq();
      run = 0;
      pulse(8'h11); pulse(8'h22); pulse(8'h33);
      total++; if (flat[0*8 +: 8] !== 8'h11) begin bad++; $display("FAIL load_m0 got=%h exp=11", flat[0*8 +: 8]); end
      total++; if (flat[1*8 +: 8] !== 8'h22) begin bad++; $display("FAIL load_m1 got=%h exp=22", flat[1*8 +: 8]); end
      total++; if (flat[2*8 +: 8] !== 8'h33) begin bad++; $display("FAIL load_m2 got=%h exp=33", flat[2*8 +: 8]); end
      total++; if (lp !== 4'd3) begin bad++; $display("FAIL load_ptr got=%0d exp=3", lp); end
      ra_a = 4'd1;
      #1;
      total++; if (rd_a !== 8'h22) begin bad++; $display("FAIL load_rd got=%h exp=22", rd_a); end
   endtask

   task automatic test_wrap_hold();
      for (int i = 0; i < 12; i++) pulse(8'h40 + 8'(i));
      total++; if (lp !== 4'd15) begin bad++; $display("FAIL fill_ptr got=%0d exp=15", lp); end
      pulse(8'hAA);
      total++; if (flat[15*8 +: 8] !== 8'hAA) begin bad++; $display("FAIL wrap_m15 got=%h exp=aa", flat[15*8 +: 8]); end
      total++; if (lp !== 4'd0) begin bad++; $display("FAIL wrap_ptr got=%0d exp=0", lp); end
      load_data   = 8'h55;
      load_strobe = 1'b1;
      repeat (10) step();
      load_strobe = 1'b0;
      step();
      total++; if (lp !== 4'd1) begin bad++; $display("FAIL hold_ptr got=%0d exp=1", lp); end
      total++; if (flat[0*8 +: 8] !== 8'h55) begin bad++; $display("FAIL hold_m0 got=%h exp=55", flat[0*8 +: 8]); end
      total++; if (flat[1*8 +: 8] !== 8'h22) begin bad++; $display("FAIL hold_m1 got=%h exp=22", flat[1*8 +: 8]); end
   endtask

   task automatic test_cpu_write();
      run = 1; write_en = 1; write_addr = 4'd5; write_data = 8'h7E;
      ra_a = 4'd5; ra_b = 4'd5;
      #1;
      total++; if (rd_a !== 8'h42) begin bad++; $display("FAIL cpu_pre_a got=%h exp=42", rd_a); end
      total++; if (rd_b !== 8'h42) begin bad++; $display("FAIL cpu_pre_b got=%h exp=42", rd_b); end
      step();
      write_en = 0;
      total++; if (rd_a !== 8'h7E) begin bad++; $display("FAIL cpu_post_a got=%h exp=7e", rd_a); end
      total++; if (rd_b !== 8'h7E) begin bad++; $display("FAIL cpu_post_b got=%h exp=7e", rd_b); end
      total++; if (flat[5*8 +: 8] !== 8'h7E) begin bad++; $display("FAIL cpu_flat got=%h exp=7e", flat[5*8 +: 8]); end
   endtask

   task automatic test_ignore();
      run = 0; write_en = 1; write_addr = 4'd3; write_data = 8'hFF;
      step();
      write_en = 0;
      total++; if (flat[3*8 +: 8] !== 8'h40) begin bad++; $display("FAIL ign_we got=%h exp=40", flat[3*8 +: 8]); end
      run = 1;
      pulse(8'h99);
      total++; if (lp !== 4'd1) begin bad++; $display("FAIL ign_load_ptr got=%0d exp=1", lp); end
      total++; if (flat[1*8 +: 8] !== 8'h22) begin bad++; $display("FAIL ign_load_m1 got=%h exp=22", flat[1*8 +: 8]); end
      run = 0;
      step();
      total++; if (lp !== 4'd1) begin bad++; $display("FAIL run_toggle_ptr got=%0d exp=1", lp); end
   endtask

   task automatic test_clr();
      run = 0;
      for (int i = 1; i <= 5; i++) pulse(8'hB0 + 8'(i));
      total++; if (lp !== 4'd6) begin bad++; $display("FAIL clr_pre_ptr got=%0d exp=6", lp); end
      load_ptr_clr = 1; load_data = 8'hEE; load_strobe = 1;
      step();
      load_ptr_clr = 0; load_strobe = 0;
      total++; if (lp !== 4'd0) begin bad++; $display("FAIL clr_ptr got=%0d exp=0", lp); end
      total++; if (flat[6*8 +: 8] !== 8'h43) begin bad++; $display("FAIL clr_m6 got=%h exp=43", flat[6*8 +: 8]); end
      total++; if (flat[0*8 +: 8] !== 8'h55) begin bad++; $display("FAIL clr_m0 got=%h exp=55", flat[0*8 +: 8]); end
      step();
   endtask

   task automatic test_reset_mid();
      run = 1; write_en = 1; write_addr = 4'd2; write_data = 8'h5A; ra_a = 4'd5;
      #2;
      rst = 1'b1;
      #1;
      total++; if (flat !== '0) begin bad++; $display("FAIL rmid_mem got=%h exp=0", flat); end
      total++; if (rd_a !== 8'h00) begin bad++; $display("FAIL rmid_rd got=%h exp=00", rd_a); end
      step();
      total++; if (flat[2*8 +: 8] !== 8'h00) begin bad++; $display("FAIL rmid_wr got=%h exp=00", flat[2*8 +: 8]); end
      write_en = 0; run = 0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_depth10();
      run = 0; load_strobe = 1'b1; load_data = 8'h66;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step(); step();
      total++; if (lp2 !== 4'd0) begin bad++; $display("FAIL d10_rel_ptr got=%0d exp=0", lp2); end
      total++; if (flat2 !== '0) begin bad++; $display("FAIL d10_rel_mem got=%h exp=0", flat2); end
      load_strobe = 1'b0;
      step();
      run = 1; write_en = 1; write_addr = 4'd12; write_data = 8'h5A; ra_a = 4'd12;
      step();
      write_en = 0;
      total++; if (rd2_a !== 8'h00) begin bad++; $display("FAIL d10_rd12 got=%h exp=00", rd2_a); end
      total++; if (flat2 !== '0) begin bad++; $display("FAIL d10_wr12 got=%h exp=0", flat2); end
      run = 0;
      for (int i = 0; i < 9; i++) pulse(8'h10 + 8'(i));
      total++; if (lp2 !== 4'd9) begin bad++; $display("FAIL d10_ptr9 got=%0d exp=9", lp2); end
      pulse(8'hC3);
      ra_b = 4'd9;
      #1;
      total++; if (lp2 !== 4'd0) begin bad++; $display("FAIL d10_wrap got=%0d exp=0", lp2); end
      total++; if (rd2_b !== 8'hC3) begin bad++; $display("FAIL d10_m9 got=%h exp=c3", rd2_b); end
      total++; if (flat2[0 +: 8] !== 8'h10) begin bad++; $display("FAIL d10_m0 got=%h exp=10", flat2[0 +: 8]); end
   endtask

   initial begin
      test_reset();
      test_load_seq();
      test_wrap_hold();
      test_cpu_write();
      test_ignore();
      test_clr();
      test_reset_mid();
      test_depth10();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
